// File: rtl/mem_block_rv.sv
// Byte-addressed data memory with a valid/ready request/response port.
// Handles sub-word loads/stores, alignment errors and optional output staging.
module mem_block_rv #(
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 4,
  parameter int OUT_REG = 0,
  localparam int AW = $clog2(DEPTH*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [8*WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [8*WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o
);

  localparam int OW = $clog2(WIDTH);
  localparam int DW = 8*WIDTH;
  localparam int IW = AW-OW;

  typedef enum logic [1:0] {
    IDLE,
    PIPE,
    RESP
  } state_t;

  localparam state_t GO = (OUT_REG != 0) ? PIPE : RESP;

  state_t state, nxt;

  logic [DW-1:0] mem [DEPTH];

  logic [OW-1:0]    off;
  logic [IW-1:0]    idx;
  int               nb;
  logic             err;
  logic [WIDTH-1:0] be;
  logic [DW-1:0]    wsh;
  logic [DW-1:0]    word;
  logic [DW-1:0]    sh;
  logic [DW-1:0]    ld;
  logic [DW-1:0]    res;
  logic             sbit;
  logic             acc;
  logic             rdy_q;
  logic [DW-1:0]    p_data;
  logic             p_err;

  // Decode request: alignment, byte enables, load extraction.
  always_comb begin
    off  = req_addr_i[OW-1:0];
    idx  = req_addr_i[AW-1:OW];
    nb   = 1 << req_size_i;
    err  = (nb > WIDTH) || ((int'(off) & (nb-1)) != 0);
    be   = '0;
    for (int b = 0; b < WIDTH; b++)
      be[b] = (b >= int'(off)) && (b < int'(off)+nb);
    wsh  = req_wdata_i << {off, 3'b000};
    word = mem[idx];
    sh   = word >> {off, 3'b000};
    sbit = 1'b0;
    for (int i = 0; i < DW; i++)
      if (i == 8*nb-1) sbit = sh[i];
    ld   = '0;
    for (int i = 0; i < DW; i++)
      ld[i] = (i < 8*nb) ? sh[i] : (sbit & ~req_unsigned_i);
    res  = (err || req_we_i) ? '0 : ld;
  end

  assign req_ready_o = rdy_q &&
    ((state == IDLE) || ((state == RESP) && rsp_ready_i));
  assign acc = req_valid_i && req_ready_o;

  // Ready is held off until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc && req_we_i && !err)
      for (int b = 0; b < WIDTH; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= nxt;
  end

  // Next state and response valid.
  always_comb begin
    nxt         = state;
    rsp_valid_o = 1'b0;
    unique case (state)
      IDLE: if (acc) nxt = GO;
      PIPE: nxt = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) nxt = acc ? GO : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Response data path; zero whenever no response is shown.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      p_data      <= '0;
      p_err       <= 1'b0;
    end else if (acc) begin
      if (OUT_REG != 0) begin
        p_data      <= res;
        p_err       <= err;
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b0;
      end else begin
        rsp_rdata_o <= res;
        rsp_err_o   <= err;
      end
    end else if (state == PIPE) begin
      rsp_rdata_o <= p_data;
      rsp_err_o   <= p_err;
    end else if ((state == RESP) && rsp_ready_i) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_block_rv.sv
// Directed bench for mem_block_rv.
// Instance u0 has OUT_REG=0, instance u1 has OUT_REG=1.
module tb_mem_block_rv;

  logic clk;
  logic rst_n;

  logic        val0, rdy0, we0, uns0, rv0, rr0, er0;
  logic [10:0] ad0;
  logic [1:0]  sz0;
  logic [31:0] wd0, rd0;

  logic        val1, rdy1, we1, uns1, rv1, rr1, er1;
  logic [10:0] ad1;
  logic [1:0]  sz1;
  logic [31:0] wd1, rd1;

  int n_cmp;
  int n_fail;

  mem_block_rv #(.OUT_REG(0)) u0 (
    .clk(clk), .rst_n_i(rst_n),
    .req_valid_i(val0), .req_ready_o(rdy0),
    .req_we_i(we0), .req_addr_i(ad0),
    .req_size_i(sz0), .req_unsigned_i(uns0),
    .req_wdata_i(wd0), .rsp_valid_o(rv0),
    .rsp_ready_i(rr0), .rsp_rdata_o(rd0),
    .rsp_err_o(er0)
  );

  mem_block_rv #(.OUT_REG(1)) u1 (
    .clk(clk), .rst_n_i(rst_n),
    .req_valid_i(val1), .req_ready_o(rdy1),
    .req_we_i(we1), .req_addr_i(ad1),
    .req_size_i(sz1), .req_unsigned_i(uns1),
    .req_wdata_i(wd1), .rsp_valid_o(rv1),
    .rsp_ready_i(rr1), .rsp_rdata_o(rd1),
    .rsp_err_o(er1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic xfer0(input logic we, input logic [10:0] a,
                       input logic [1:0] s, input logic u,
                       input logic [31:0] w, output logic v,
                       output logic [31:0] d, output logic e);
    @(negedge clk);
    val0 = 1'b1; we0 = we; ad0 = a;
    sz0 = s; uns0 = u; wd0 = w; rr0 = 1'b1;
    @(negedge clk);
    val0 = 1'b0;
    v = rv0; d = rd0; e = er0;
  endtask

  task automatic xfer1(input logic we, input logic [10:0] a,
                       input logic [1:0] s, input logic [31:0] w,
                       output logic v, output logic [31:0] d,
                       output logic e);
    @(negedge clk);
    val1 = 1'b1; we1 = we; ad1 = a;
    sz1 = s; uns1 = 1'b0; wd1 = w; rr1 = 1'b1;
    @(negedge clk);
    val1 = 1'b0;
    @(negedge clk);
    v = rv1; d = rd1; e = er1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready0 got %b want 0", rdy0);
    end
    n_cmp++;
    if ({rv0, er0, rd0} !== 34'h0) begin
      n_fail++;
      $display("FAIL rst_rsp0 got %b %b %h want 0", rv0, er0, rd0);
    end
    n_cmp++;
    if (rdy1 !== 1'b0 || rv1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_u1 got rdy %b v %b want 0 0", rdy1, rv1);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_ready0 got %b want 0", rdy0);
    end
    @(negedge clk);
    n_cmp++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rel_ready got %b %b want 1 1", rdy0, rdy1);
    end
  endtask

  task automatic test_store_load;
    logic v, e;
    logic [31:0] d;
    xfer0(1'b1, 11'h10, 2'd2, 1'b0, 32'hDEADBEEF, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL sw10 got v%b e%b %h want v1 e0 0", v, e, d);
    end
    xfer0(1'b0, 11'h10, 2'd2, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL lw10 got v%b e%b %h want v1 e0 deadbeef",
               v, e, d);
    end
  endtask

  task automatic test_subword;
    logic v, e;
    logic [31:0] d;
    xfer0(1'b1, 11'h13, 2'd0, 1'b0, 32'h000000A5, v, d, e);
    xfer0(1'b0, 11'h10, 2'd2, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if (d !== 32'hA5ADBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_after_sb got %h want a5adbeef", d);
    end
    xfer0(1'b0, 11'h13, 2'd0, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if (d !== 32'hFFFFFFA5) begin
      n_fail++;
      $display("FAIL lb13 got %h want ffffffa5", d);
    end
    xfer0(1'b0, 11'h13, 2'd0, 1'b1, 32'h0, v, d, e);
    n_cmp++;
    if (d !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL lbu13 got %h want 000000a5", d);
    end
    xfer0(1'b0, 11'h12, 2'd1, 1'b1, 32'h0, v, d, e);
    n_cmp++;
    if (d !== 32'h0000A5AD) begin
      n_fail++;
      $display("FAIL lhu12 got %h want 0000a5ad", d);
    end
  endtask

  task automatic test_errors;
    logic v, e;
    logic [31:0] d;
    xfer0(1'b0, 11'h11, 2'd1, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL lh11 got v%b e%b %h want v1 e1 0", v, e, d);
    end
    xfer0(1'b1, 11'h12, 2'd2, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL sw12 got v%b e%b %h want v1 e1 0", v, e, d);
    end
    xfer0(1'b0, 11'h10, 2'd3, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL sz3 got v%b e%b %h want v1 e1 0", v, e, d);
    end
    xfer0(1'b0, 11'h10, 2'd2, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if (d !== 32'hA5ADBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_after_err got %h e%b want a5adbeef e0", d, e);
    end
  endtask

  task automatic test_stall;
    logic v, e;
    logic [31:0] d;
    @(negedge clk);
    val0 = 1'b1; we0 = 1'b0; ad0 = 11'h10;
    sz0 = 2'd2; uns0 = 1'b0; wd0 = 32'h0; rr0 = 1'b0;
    @(negedge clk);
    we0 = 1'b1; ad0 = 11'h18; wd0 = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if ({rv0, er0, rd0, rdy0} !== {1'b1, 1'b0, 32'hA5ADBEEF, 1'b0})
      begin
        n_fail++;
        $display("FAIL stall%0d got v%b e%b %h rdy%b want v1 e0 a5adbeef rdy0",
                 k, rv0, er0, rd0, rdy0);
      end
    end
    rr0 = 1'b1;
    #1;
    n_cmp++;
    if (rdy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready got %b want 1", rdy0);
    end
    @(negedge clk);
    val0 = 1'b0;
    n_cmp++;
    if ({rv0, er0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL b2b_store_rsp got v%b e%b %h want v1 e0 0",
               rv0, er0, rd0);
    end
    xfer0(1'b0, 11'h18, 2'd2, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if (d !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL lw18 got %h want cafef00d", d);
    end
  endtask

  task automatic test_reset_mid;
    logic v, e;
    logic [31:0] d;
    @(negedge clk);
    val0 = 1'b1; we0 = 1'b1; ad0 = 11'h20;
    sz0 = 2'd2; uns0 = 1'b0; wd0 = 32'h11223344; rr0 = 1'b0;
    @(negedge clk);
    val0 = 1'b0;
    n_cmp++;
    if (rv0 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_rst_valid got %b want 1", rv0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rv0 !== 1'b0 || rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst got v%b rdy%b want 0 0", rv0, rdy0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rr0 = 1'b1;
    @(negedge clk);
    xfer0(1'b0, 11'h20, 2'd2, 1'b0, 32'h0, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b0, 32'h11223344}) begin
      n_fail++;
      $display("FAIL lw20_after_rst got v%b e%b %h want v1 e0 11223344",
               v, e, d);
    end
  endtask

  task automatic test_back_to_back;
    logic v, e;
    logic [31:0] d;
    xfer1(1'b1, 11'h10, 2'd2, 32'hDEADBEEF, v, d, e);
    n_cmp++;
    if ({v, e, d} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL u1_sw10 got v%b e%b %h want v1 e0 0", v, e, d);
    end
    xfer1(1'b1, 11'h14, 2'd2, 32'h01020304, v, d, e);
    @(negedge clk);
    val1 = 1'b1; we1 = 1'b0; ad1 = 11'h10;
    sz1 = 2'd2; uns1 = 1'b0; rr1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rdy1, rv1, rd1} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL u1_pipe1 got rdy%b v%b %h want rdy0 v0 0",
               rdy1, rv1, rd1);
    end
    ad1 = 11'h14;
    @(negedge clk);
    n_cmp++;
    if ({rv1, er1, rd1, rdy1} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b1})
    begin
      n_fail++;
      $display("FAIL u1_resp1 got v%b e%b %h rdy%b want v1 e0 deadbeef rdy1",
               rv1, er1, rd1, rdy1);
    end
    @(negedge clk);
    val1 = 1'b0;
    n_cmp++;
    if ({rdy1, rv1, rd1} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL u1_pipe2 got rdy%b v%b %h want rdy0 v0 0",
               rdy1, rv1, rd1);
    end
    @(negedge clk);
    n_cmp++;
    if ({rv1, er1, rd1} !== {1'b1, 1'b0, 32'h01020304}) begin
      n_fail++;
      $display("FAIL u1_resp2 got v%b e%b %h want v1 e0 01020304",
               rv1, er1, rd1);
    end
    @(negedge clk);
    n_cmp++;
    if ({rv1, rd1} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL u1_idle got v%b %h want v0 0", rv1, rd1);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b1;
    val0 = 1'b0; we0 = 1'b0; ad0 = '0; sz0 = '0;
    uns0 = 1'b0; wd0 = '0; rr0 = 1'b1;
    val1 = 1'b0; we1 = 1'b0; ad1 = '0; sz1 = '0;
    uns1 = 1'b0; wd1 = '0; rr1 = 1'b1;
    test_reset();
    test_store_load();
    test_subword();
    test_errors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_block_rv.md
MEM_BLOCK_RV -- requirements
Module: mem_block_rv

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning the number of words; it must be a power of 2.
REQ-002 The block SHALL have parameter WIDTH, default 4, meaning bytes per word; legal values are 4 and 8.
REQ-003 The block SHALL have parameter OUT_REG, default 0, meaning an extra output pipeline stage when set to 1.
REQ-004 Derived width AW SHALL equal $clog2(DEPTH*WIDTH), the byte-address width.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  input  1  request present.
REQ-008 req_ready_o  output  1  block accepts a request this cycle.
REQ-009 req_we_i  input  1  1 = store, 0 = load.
REQ-010 req_addr_i  input  AW  byte address.
REQ-011 req_size_i  input  2  access size: 0 = byte, 1 = half, 2 = word(32), 3 = double(64).
REQ-012 req_unsigned_i  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-013 req_wdata_i  input  8*WIDTH  store data, right-aligned (lane 0 holds the LSB).
REQ-014 rsp_valid_o  output  1  response present.
REQ-015 rsp_ready_i  input  1  consumer takes the response.
REQ-016 rsp_rdata_o  output  8*WIDTH  load data, right-aligned and extended.
REQ-017 rsp_err_o  output  1  request was misaligned or had an illegal size.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid_i && req_ready_o.
REQ-019 Offset SHALL be addr[$clog2(WIDTH)-1:0], and the word index SHALL be the remaining upper address bits.
REQ-020 A request SHALL be in error when size bytes exceed WIDTH (for example size 3 with WIDTH=4), or when offset is not a multiple of the size in bytes.
REQ-021 An errored request SHALL not read or write the array, and SHALL produce a response with rsp_err_o=1 and rsp_rdata_o=0.
REQ-022 A legal store SHALL write req_wdata_i shifted left by 8*offset.
REQ-023 The store byte-enable for a legal store SHALL be ((1<<size bytes)-1)<<offset, and unmasked bytes SHALL be unchanged.
REQ-024 A legal store SHALL commit at the accept edge, and its response SHALL carry rdata=0 and err=0.
REQ-025 A legal load SHALL read the word at the accept edge, shift it right by 8*offset, keep the size bytes, and sign-extend or zero-extend to 8*WIDTH according to req_unsigned_i.
REQ-026 A load issued after a store to the same word SHALL return the stored data; no forwarding is needed because accesses are sequential.
REQ-027 The FSM SHALL have states IDLE, PIPE and RESP.
REQ-028 In IDLE, req_ready_o SHALL be 1; on accept the FSM SHALL go to RESP when OUT_REG=0 and to PIPE when OUT_REG=1.
REQ-029 In PIPE, req_ready_o SHALL be 0, rsp_valid_o SHALL be 0, and the FSM SHALL go to RESP after one cycle unconditionally.
REQ-030 In RESP, rsp_valid_o SHALL be 1 and req_ready_o SHALL equal rsp_ready_i.
REQ-031 In RESP with rsp_ready_i=0, the FSM SHALL hold state, and rsp_rdata_o and rsp_err_o SHALL stay stable.
REQ-032 In RESP with rsp_ready_i=1 and a new request accepted in the same cycle, the FSM SHALL go to RESP (OUT_REG=0) or PIPE (OUT_REG=1); with no new request it SHALL go to IDLE.
REQ-033 Load-to-response latency SHALL be 1 cycle for OUT_REG=0 and 2 cycles for OUT_REG=1.
REQ-034 Throughput SHALL be 1 request per cycle for OUT_REG=0 under continuous rsp_ready_i=1, and 1 request per 2 cycles for OUT_REG=1.
REQ-035 Only one transaction SHALL be in flight at a time; req_valid_i is ignored while req_ready_o=0.
REQ-036 rsp_rdata_o and rsp_err_o SHALL be registered outputs, and SHALL be 0 whenever rsp_valid_o=0.

Reset
REQ-037 On rst_n_i low, asynchronously, the FSM SHALL go to IDLE and rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL be 0.
REQ-038 req_ready_o SHALL be 0 while rst_n_i is low, and SHALL be 1 from the first edge after release.
REQ-039 Array contents SHALL not be reset.
REQ-040 Reset mid-operation SHALL drop any pending response, while a store already committed at its accept edge SHALL persist.

Verification
REQ-041 OUT_REG=0, WIDTH=4: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid_o high exactly 1 cycle after accept.
REQ-042 After REQ-041: SB 0x13 data 0xA5, then LW 0x10 -> 0xA5ADBEEF; LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5; LHU 0x12 -> 0x0000A5AD.
REQ-043 LH 0x11, SW 0x12 data 0x0, and size 3 at 0x10 -> each returns err 1, rdata 0; a following LW 0x10 -> 0xA5ADBEEF, unchanged.
REQ-044 Hold rsp_ready_i=0 for 3 cycles during a load response -> rsp_valid_o, rdata and err held stable, req_ready_o=0; raise rsp_ready_i with a new request presented -> accepted in the same cycle.
REQ-045 OUT_REG=1: back-to-back LW requests with rsp_ready_i=1 -> 2-cycle latency, req_ready_o low in PIPE, one response every 2 cycles.
REQ-046 Assert rst_n_i low while in RESP after SW 0x20 data 0x11223344 -> rsp_valid_o drops to 0 immediately; after release, LW 0x20 -> 0x11223344.
